// File: rtl/xge_wb_arbiter.sv
// Round-robin arbiter sharing the MAC Wishbone slave port between NUM_REQ control-plane
// requesters; one single-beat transaction at a time with optional stall timeout.
module xge_wb_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [8*NUM_REQ-1:0]   req_adr,
    input  logic [32*NUM_REQ-1:0]  req_dat,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_dat,
    output logic                   rsp_err,
    output logic [7:0]             wb_adr_o,
    output logic [31:0]            wb_dat_o,
    output logic                   wb_we_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    input  logic [31:0]            wb_dat_i,
    input  logic                   wb_ack_i,
    output logic [15:0]            timeout_cnt
);

    localparam int unsigned ADR_W = 8;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned TOC_W = 16;
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TOC_W-1:0] TOC_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADR_W-1:0]   wb_adr_d;
    logic [DAT_W-1:0]   wb_dat_d;
    logic               wb_we_d, wb_cyc_d, wb_stb_d;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_d;
    logic               rsp_err_d;
    logic [TOC_W-1:0]   timeout_cnt_d;

    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   idx;
    logic               any_req;

    // First pending requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        winner  = rr_ptr_q;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        wb_adr_d      = wb_adr_o;
        wb_dat_d      = wb_dat_o;
        wb_we_d       = wb_we_o;
        wb_cyc_d      = wb_cyc_o;
        wb_stb_d      = wb_stb_o;
        rsp_valid_d   = '0;
        rsp_dat_d     = rsp_dat;
        rsp_err_d     = rsp_err;
        timeout_cnt_d = timeout_cnt;
        req_ready     = '0;

        case (state_q)
            IDLE: begin
                if (any_req && !wb_rst_i) begin
                    req_ready = NUM_REQ'(1) << winner;
                    state_d   = BUS;
                    owner_d   = winner;
                    rr_ptr_d  = (32'(winner) + 1 == NUM_REQ) ? '0 : winner + PTR_W'(1);
                    cnt_d     = '0;
                    wb_cyc_d  = 1'b1;
                    wb_stb_d  = 1'b1;
                    wb_we_d   = req_we[winner];
                    wb_adr_d  = req_adr[32'(winner)*ADR_W +: ADR_W];
                    wb_dat_d  = req_we[winner] ? req_dat[32'(winner)*DAT_W +: DAT_W] : '0;
                end
            end
            BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack takes priority over a simultaneous timeout.
                if (wb_ack_i || (TIMEOUT_EN && cnt_q == CNT_LAST)) begin
                    state_d     = RESP;
                    wb_cyc_d    = 1'b0;
                    wb_stb_d    = 1'b0;
                    wb_we_d     = 1'b0;
                    wb_adr_d    = '0;
                    wb_dat_d    = '0;
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    if (wb_ack_i) begin
                        rsp_dat_d = wb_we_o ? '0 : wb_dat_i;
                        rsp_err_d = 1'b0;
                    end else begin
                        rsp_dat_d = '0;
                        rsp_err_d = 1'b1;
                        if (timeout_cnt != TOC_MAX) begin
                            timeout_cnt_d = timeout_cnt + TOC_W'(1);
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid   <= '0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            wb_adr_o    <= wb_adr_d;
            wb_dat_o    <= wb_dat_d;
            wb_we_o     <= wb_we_d;
            wb_cyc_o    <= wb_cyc_d;
            wb_stb_o    <= wb_stb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_dat     <= rsp_dat_d;
            rsp_err     <= rsp_err_d;
            timeout_cnt <= timeout_cnt_d;
        end
    end

endmodule

// File: tb/tb_xge_wb_arbiter.sv
// Randomized bench for xge_wb_arbiter against a transaction-level round-robin / timing model.
module tb_xge_wb_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned TO = 16;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_we;
    logic [8*N-1:0]    req_adr;
    logic [32*N-1:0]   req_dat;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_dat;
    logic              rsp_err;
    logic [7:0]        wb_adr_o;
    logic [31:0]       wb_dat_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [31:0]       wb_dat_i;
    logic              wb_ack_i;
    logic [15:0]       timeout_cnt;

    always #5 wb_clk_i = ~wb_clk_i;

    xge_wb_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_adr     (req_adr),
        .req_dat     (req_dat),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .timeout_cnt (timeout_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Requester-side view: pending requests held until granted.
    bit          pend  [N];
    bit          p_we  [N];
    logic [7:0]  p_adr [N];
    logic [31:0] p_dat [N];
    int          rr;
    int          to_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < int'(N); i++) begin
            req_valid[i]       = pend[i];
            req_we[i]          = p_we[i];
            req_adr[8*i +: 8]  = p_adr[i];
            req_dat[32*i +: 32] = p_dat[i];
        end
    endtask

    task automatic add_req(input int i, input bit we, input logic [7:0] a, input logic [31:0] d);
        if (!pend[i]) begin
            pend[i]  = 1'b1;
            p_we[i]  = we;
            p_adr[i] = a;
            p_dat[i] = d;
        end
    endtask

    function automatic int pick();
        for (int i = 0; i < int'(N); i++) begin
            int j;
            j = (rr + i) % int'(N);
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    // One arbitration slot starting at an IDLE negedge; k = stb cycle index of the MAC ack.
    task automatic run_txn(input int k, input logic [31:0] rdata);
        int          w;
        int          stb_len;
        bit          timed_out;
        bit          we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [31:0] rd;
        chk("idle_cyc", 32'(wb_cyc_o), 32'd0);
        chk("idle_stb", 32'(wb_stb_o), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        drive_reqs();
        #1;
        w = pick();
        if (w < 0) begin
            chk("ready_none", 32'(req_ready), 32'd0);
            @(negedge wb_clk_i);
            return;
        end
        chk("grant", 32'(req_ready), 32'd1 << w);
        we  = p_we[w];
        adr = p_adr[w];
        dat = p_dat[w];
        rr  = (w + 1) % int'(N);
        pend[w] = 1'b0;
        @(negedge wb_clk_i);
        drive_reqs();
        timed_out = (TO != 0) && (k >= int'(TO));
        stb_len   = timed_out ? int'(TO) : k + 1;
        rd = '0;
        for (int c = 0; c < stb_len; c++) begin
            chk("bus_cyc", 32'(wb_cyc_o), 32'd1);
            chk("bus_stb", 32'(wb_stb_o), 32'd1);
            chk("bus_adr", 32'(wb_adr_o), 32'(adr));
            chk("bus_we", 32'(wb_we_o), 32'(we));
            chk("bus_dat", wb_dat_o, we ? dat : 32'd0);
            #1;
            chk("bus_ready", 32'(req_ready), 32'd0);
            wb_ack_i = (c == k);
            wb_dat_i = (c == k) ? rdata : $urandom;
            if (c == k) rd = rdata;
            @(negedge wb_clk_i);
        end
        wb_ack_i = 1'b0;
        if (timed_out && to_cnt < 65535) to_cnt++;
        chk("resp_cyc", 32'(wb_cyc_o), 32'd0);
        chk("resp_stb", 32'(wb_stb_o), 32'd0);
        chk("resp_valid", 32'(rsp_valid), 32'd1 << w);
        chk("resp_dat", rsp_dat, timed_out ? 32'd0 : (we ? 32'd0 : rd));
        chk("resp_err", 32'(rsp_err), 32'(timed_out));
        chk("timeout_cnt", 32'(timeout_cnt), 32'(to_cnt));
        #1;
        chk("resp_ready", 32'(req_ready), 32'd0);
        @(negedge wb_clk_i);
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) begin
            pend[i] = 1'b0; p_we[i] = 1'b0; p_adr[i] = '0; p_dat[i] = '0;
        end
        rr = 0;
        to_cnt = 0;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        req_we = '0;
        req_adr = '0;
        req_dat = '0;
        req_valid = '1;
        wb_rst_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_toc", 32'(timeout_cnt), 32'd0);
        req_valid = '0;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // Single read, ack on third stb cycle.
        add_req(0, 1'b0, 8'h08, 32'hDEAD_BEEF);
        run_txn(2, 32'h0000_00A5);
        // Write with no ack: full timeout.
        add_req(1, 1'b1, 8'h00, 32'h1);
        run_txn(1000, 32'h0);
        // Ack on the last allowed stb cycle.
        add_req(0, 1'b0, 8'h44, 32'h0);
        run_txn(int'(TO) - 1, 32'h5A5A_0001);
        // Contention with immediate acks.
        for (int t = 0; t < 4; t++) begin
            add_req(0, 1'($urandom), 8'($urandom), $urandom);
            add_req(1, 1'($urandom), 8'($urandom), $urandom);
            run_txn(0, $urandom);
        end
        run_txn(0, $urandom);
        // Back-to-back writes from requester 0 only.
        for (int t = 0; t < 4; t++) begin
            add_req(0, 1'b1, 8'(8'h10 + t), $urandom);
            run_txn(0, $urandom);
        end

        // Randomized phase.
        repeat (150) begin
            if ($urandom_range(0, 9) != 0) begin
                for (int i = 0; i < int'(N); i++) begin
                    if ($urandom_range(0, 3) != 0)
                        add_req(i, 1'($urandom), 8'($urandom), $urandom);
                end
            end
            run_txn(($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3))
                                               : int'($urandom_range(0, 20)), $urandom);
        end
        repeat (N) run_txn(0, $urandom);

        // Reset during the third stb cycle; pointer must return to requester 0.
        add_req(0, 1'b1, 8'h33, 32'h1234);
        drive_reqs();
        #1;
        chk("mrst_grant", 32'(req_ready), 32'd1);
        pend[0] = 1'b0;
        @(negedge wb_clk_i);
        add_req(0, 1'b0, 8'h21, 32'h0);
        add_req(1, 1'b0, 8'h22, 32'h0);
        drive_reqs();
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("mrst_stb_before", 32'(wb_stb_o), 32'd1);
        wb_rst_i = 1'b1;
        #1;
        chk("mrst_ready", 32'(req_ready), 32'd0);
        @(negedge wb_clk_i);
        chk("mrst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("mrst_stb", 32'(wb_stb_o), 32'd0);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_toc", 32'(timeout_cnt), 32'd0);
        wb_rst_i = 1'b0;
        rr = 0;
        to_cnt = 0;
        run_txn(0, 32'h0000_0077);
        run_txn(1, 32'h0000_0088);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
